// File: rtl/reg_serializer_pkg.sv
// Shared types and constants for the parallel-to-serial transmitter.
package reg_serializer_pkg;

    // Frame sequencing: idle line, data bits, then the trailing parity bit.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

    localparam int   DEFAULT_WIDTH = 8;
    localparam logic IDLE_LEVEL    = 1'b1;

    // Bit counter width; a one-bit word still needs a one-bit counter.
    function automatic int counterWidth(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/reg_serializer_hold.sv
// One-entry hold buffer: keeps the next word while a frame is on the line.
module ser_hold
    import reg_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    logic [WIDTH-1:0] r_data;
    logic             r_full;

    // Capture a word and mark it present; draining only drops the flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/reg_serializer.sv
// Parallel-to-serial transmitter: WIDTH data bits followed by an even-parity
// bit, with a one-word hold buffer so consecutive frames run back to back.
module reg_serializer
    import reg_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ena,
    input  logic [WIDTH-1:0] R,
    input  logic             r_valid,
    output logic             r_ready,
    output logic             sout,
    output logic             sframe,
    output logic             done
);

    localparam int CW = counterWidth(WIDTH);

    ser_state_t       r_state;
    ser_state_t       w_stateNext;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shiftNext;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_startWord;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_countNext;
    logic             r_sout;
    logic             w_soutNext;
    logic             r_sframe;
    logic             r_parity;
    logic             w_parityNext;
    logic             w_start;
    logic             w_holdLoad;
    logic             w_holdClear;
    logic             w_holdFull;
    logic [WIDTH-1:0] w_holdData;
    logic             w_ready;
    logic             w_transfer;

    // The bit that leaves first from a word, honouring the shift direction.
    function automatic logic firstBit(input logic [WIDTH-1:0] word);
        return (MSB_FIRST != 0) ? word[WIDTH-1] : word[0];
    endfunction

    assign w_ready    = ena & ~w_holdFull & ~reset;
    assign w_transfer = r_valid & w_ready;

    ser_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_holdLoad),
        .i_clear (w_holdClear),
        .i_data  (R),
        .o_data  (w_holdData),
        .o_full  (w_holdFull)
    );

    // Next-state and datapath decode; everything holds unless ena is high.
    // sout is registered, so each branch computes the bit for the next cycle.
    // A word caught by the hold buffer during the final parity cycle lands in
    // IDLE with the buffer full; IDLE drains it so it is never stranded.
    always_comb begin
        w_stateNext  = r_state;
        w_shiftNext  = r_shift;
        w_countNext  = r_count;
        w_soutNext   = r_sout;
        w_parityNext = r_parity;
        w_start      = 1'b0;
        w_startWord  = R;
        w_holdLoad   = 1'b0;
        w_holdClear  = 1'b0;
        w_shifted    = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);

        if (ena) begin
            unique case (r_state)
                IDLE: begin
                    if (w_transfer) begin
                        w_start     = 1'b1;
                        w_startWord = R;
                    end else if (w_holdFull) begin
                        w_start     = 1'b1;
                        w_startWord = w_holdData;
                        w_holdClear = 1'b1;
                    end
                end
                SHIFT: begin
                    w_holdLoad = w_transfer;
                    if (r_count == '0) begin
                        w_stateNext = PARITY;
                        w_soutNext  = r_parity;
                    end else begin
                        w_shiftNext = w_shifted;
                        w_soutNext  = firstBit(w_shifted);
                        w_countNext = r_count - CW'(1);
                    end
                end
                PARITY: begin
                    w_holdLoad = w_transfer;
                    if (w_holdFull) begin
                        w_start     = 1'b1;
                        w_startWord = w_holdData;
                        w_holdClear = 1'b1;
                    end else begin
                        w_stateNext = IDLE;
                        w_soutNext  = IDLE_LEVEL;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                    w_soutNext  = IDLE_LEVEL;
                end
            endcase

            if (w_start) begin
                w_stateNext  = SHIFT;
                w_shiftNext  = w_startWord;
                w_countNext  = CW'(WIDTH - 1);
                w_soutNext   = firstBit(w_startWord);
                w_parityNext = ^w_startWord;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Shift register, bit counter, parity and registered line outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift  <= '0;
            r_count  <= '0;
            r_parity <= 1'b0;
            r_sout   <= IDLE_LEVEL;
            r_sframe <= 1'b0;
        end else begin
            r_shift  <= w_shiftNext;
            r_count  <= w_countNext;
            r_parity <= w_parityNext;
            r_sout   <= w_soutNext;
            r_sframe <= (w_stateNext != IDLE);
        end
    end

    assign r_ready = w_ready;
    assign sout    = r_sout;
    assign sframe  = r_sframe;
    assign done    = (r_state == PARITY) & ena & ~reset;

endmodule

// File: tb/tb_reg_serializer.sv
// Scoreboard bench for reg_serializer: one MSB-first and one LSB-first instance.
module tb_reg_serializer;

    typedef struct {
        logic b;
        logic d;
        int   id;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] R = 8'h00;
    logic       r_valid = 1'b0;
    logic       r_valid2 = 1'b0;
    logic       r_ready, sout, sframe, done;
    logic       r_ready2, sout2, sframe2, done2;

    exp_t q[$];
    exp_t q2[$];
    exp_t e1;
    exp_t e2;
    int   nextId = 0;
    int   totalChecks = 0;
    int   badChecks = 0;
    logic lastExpBit = 1'b1;
    bit   expHold;

    reg_serializer #(.WIDTH(8), .MSB_FIRST(1)) dutMsb (
        .clock   (clock),
        .reset   (reset),
        .ena     (ena),
        .R       (R),
        .r_valid (r_valid),
        .r_ready (r_ready),
        .sout    (sout),
        .sframe  (sframe),
        .done    (done)
    );

    reg_serializer #(.WIDTH(8), .MSB_FIRST(0)) dutLsb (
        .clock   (clock),
        .reset   (reset),
        .ena     (ena),
        .R       (R),
        .r_valid (r_valid2),
        .r_ready (r_ready2),
        .sout    (sout2),
        .sframe  (sframe2),
        .done    (done2)
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line bits of one frame, appended when the DUT accepts the word.
    function automatic void pushFrame(input logic [7:0] word, input bit sel);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.b  = sel ? word[i] : word[7-i];
            e.d  = 1'b0;
            e.id = nextId;
            if (sel) q2.push_back(e); else q.push_back(e);
        end
        e.b  = ^word;
        e.d  = 1'b1;
        e.id = nextId;
        if (sel) q2.push_back(e); else q.push_back(e);
        nextId++;
    endfunction

    // Offer a word; called just after a rising edge, returns just after the accepting edge.
    task automatic applyStimulus(input logic [7:0] word, input bit sel);
        int waited;
        bit seen;
        waited = 0;
        seen   = 0;
        R = word;
        if (sel) r_valid2 = 1'b1; else r_valid = 1'b1;
        while (!seen && waited < 100) begin
            @(negedge clock);
            if ((sel ? r_ready2 : r_ready) === 1'b1) seen = 1; else waited++;
        end
        if (!seen) begin
            checkOutput("accept_timeout", {31'b0, seen}, 32'd1);
        end else begin
            @(posedge clock);
            #1;
            pushFrame(word, sel);
        end
        r_valid  = 1'b0;
        r_valid2 = 1'b0;
        R = 8'($urandom_range(0, 255));
    endtask

    // Wait, bounded, until both scoreboards have drained.
    task automatic waitDrain();
        int n;
        n = 0;
        while ((q.size() != 0 || q2.size() != 0) && n < 200) begin
            @(negedge clock);
            n++;
        end
        checkOutput("drain", q.size() + q2.size(), 0);
        @(posedge clock);
        #1;
    endtask

    // MSB-first monitor: line level, framing, done and r_ready against the scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            checkOutput("ready_in_reset", {31'b0, r_ready}, 32'd0);
            checkOutput("done_in_reset", {31'b0, done}, 32'd0);
        end else begin
            expHold = 0;
            for (int i = 1; i < q.size(); i++) begin
                if (q[i].id != q[0].id) expHold = 1;
            end
            checkOutput("r_ready", {31'b0, r_ready}, {31'b0, ena && !expHold});
            checkOutput("sframe", {31'b0, sframe}, {31'b0, q.size() != 0});
            if (q.size() == 0) begin
                checkOutput("sout_idle", {31'b0, sout}, 32'd1);
                checkOutput("done_idle", {31'b0, done}, 32'd0);
            end else if (!ena) begin
                checkOutput("sout_frozen", {31'b0, sout}, {31'b0, lastExpBit});
                checkOutput("done_frozen", {31'b0, done}, 32'd0);
            end else begin
                e1 = q.pop_front();
                lastExpBit = e1.b;
                checkOutput(e1.d ? "parity_bit" : "data_bit", {31'b0, sout}, {31'b0, e1.b});
                checkOutput("done", {31'b0, done}, {31'b0, e1.d});
            end
        end
    end

    // LSB-first monitor: line level, framing and done.
    always @(negedge clock) begin
        if (!reset) begin
            checkOutput("lsb_sframe", {31'b0, sframe2}, {31'b0, q2.size() != 0});
            if (q2.size() == 0) begin
                checkOutput("lsb_sout_idle", {31'b0, sout2}, 32'd1);
            end else if (ena) begin
                e2 = q2.pop_front();
                checkOutput("lsb_bit", {31'b0, sout2}, {31'b0, e2.b});
                checkOutput("lsb_done", {31'b0, done2}, {31'b0, e2.d});
            end
        end
    end

    // Stimulus sequence.
    initial begin
        int n;
        logic [7:0] w;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("ready_after_reset", {31'b0, r_ready}, 32'd1);
        repeat (3) @(posedge clock);
        #1;

        $display("[TB] single frame 0xAA");
        applyStimulus(8'hAA, 0);
        waitDrain();

        $display("[TB] back-to-back 0xAA then 0x55");
        applyStimulus(8'hAA, 0);
        applyStimulus(8'h55, 0);
        waitDrain();

        $display("[TB] LSB-first 0x07");
        applyStimulus(8'h07, 1);
        waitDrain();

        $display("[TB] 0xFF with ena low for 3 cycles");
        applyStimulus(8'hFF, 0);
        @(posedge clock);
        #1;
        ena = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        ena = 1'b1;
        waitDrain();

        $display("[TB] reset mid-frame with a word held");
        applyStimulus(8'hAA, 0);
        applyStimulus(8'h55, 0);
        n = 0;
        while (q.size() > 14 && n < 100) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        q.delete();
        reset = 1'b0;
        @(negedge clock);
        checkOutput("abort_sout", {31'b0, sout}, 32'd1);
        checkOutput("abort_ready", {31'b0, r_ready}, 32'd1);
        repeat (25) @(posedge clock);
        #1;

        $display("[TB] random back-to-back words");
        for (int k = 0; k < 4; k++) begin
            w = 8'($urandom_range(0, 255));
            applyStimulus(w, k[0]);
        end
        waitDrain();
        repeat (3) @(posedge clock);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
